mem_dump: RTL and testbench

- Hardware reader for CPU program/data memory; the counterpart of the bench/boot path that writes images into memory.
- On `start`, holds the CPU and reads `length` consecutive 16-bit words from `start_addr`.
- Streams each word as two bytes, high byte first, over a byte-wide valid/ready interface, typically feeding a UART TX.
- Sits between the cpu_mem read port (muxed in while `cpu_hold`=1) and the board serial path.

---
 rtl/mem_dump.sv | 150 +++++++++++++++
 tb/tb_mem_dump.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump.sv
`default_nettype none
// ============================================================================
// Module      : mem_dump
// Description : Reads consecutive 16-bit memory words while holding the CPU.
//               Streams each word high byte first over a byte-wide
//               valid/ready interface.
//               Optional checksum trailer: define DUMP_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_dump #(
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [15:0]           mem_rdata,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_hold
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_SEND_HI = 3'd3;
    localparam logic [2:0] S_SEND_LO = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;
    localparam logic [2:0] S_CSUM_HI = 3'd6;
    localparam logic [2:0] S_CSUM_LO = 3'd7;

`ifdef DUMP_CHECKSUM_EN
    localparam logic [2:0] S_AFTER_LAST = S_CSUM_HI;
`else
    localparam logic [2:0] S_AFTER_LAST = S_FINISH;
`endif

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [15:0]           word_q, word_d;
    logic                  w_hs;

`ifdef DUMP_CHECKSUM_EN
    logic [15:0]           sum_q, sum_d;
`endif

    assign w_hs = tx_valid & tx_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        word_d      = word_q;
`ifdef DUMP_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = start_addr;
                    remaining_d = length;
`ifdef DUMP_CHECKSUM_EN
                    sum_d       = 16'h0000;
                    state_d     = (length != '0) ? S_READ : S_CSUM_HI;
`else
                    // A zero-length dump idles one cycle in WAIT so done lands two cycles after start.
                    state_d     = (length != '0) ? S_READ : S_WAIT;
`endif
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                if (remaining_q == '0) begin
                    state_d = S_FINISH;
                end else begin
                    word_d  = mem_rdata;
`ifdef DUMP_CHECKSUM_EN
                    sum_d   = sum_q + mem_rdata;
`endif
                    state_d = S_SEND_HI;
                end
            end
            S_SEND_HI: if (w_hs) state_d = S_SEND_LO;
            S_SEND_LO: begin
                if (w_hs) begin
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    state_d     = (remaining_q == LEN_WIDTH'(1)) ? S_AFTER_LAST : S_READ;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM_HI: if (w_hs) state_d = S_CSUM_LO;
            S_CSUM_LO: if (w_hs) state_d = S_FINISH;
`endif
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            word_q      <= 16'h0000;
`ifdef DUMP_CHECKSUM_EN
            sum_q       <= 16'h0000;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            word_q      <= word_d;
`ifdef DUMP_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // Outputs decode straight from state so reset clears them without waiting for a clock.
    always_comb begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        case (state_q)
            S_SEND_HI: begin tx_data = word_q[15:8]; tx_valid = 1'b1; end
            S_SEND_LO: begin tx_data = word_q[7:0];  tx_valid = 1'b1; end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM_HI: begin tx_data = sum_q[15:8];  tx_valid = 1'b1; end
            S_CSUM_LO: begin tx_data = sum_q[7:0];   tx_valid = 1'b1; end
`endif
            default: begin tx_data = 8'h00; tx_valid = 1'b0; end
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_rd_en = (state_q == S_READ);
    assign busy      = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign cpu_hold  = busy;
    assign done      = (state_q == S_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_mem_dump.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_dump
// Description : Scoreboard bench for mem_dump; expected bytes are queued by
//               the stimulus and popped by a monitor on each handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dump;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_addr = 16'h0000;
    logic [15:0] length = 16'h0000;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rdata = 16'h0000;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        cpu_hold;

    mem_dump #(.ADDR_WIDTH(16), .LEN_WIDTH(16)) dut (
        .CLK(CLK), .RST(RST), .start(start), .start_addr(start_addr),
        .length(length), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .cpu_hold(cpu_hold)
    );

    always #5 CLK = ~CLK;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;
    logic [15:0] mem [0:65535];
    logic [7:0]  exp_q [$];
    logic [15:0] rd_addr_q [$];
    int          rd_first_cyc, first_valid, done_cnt, done_cyc, byte_cnt, hold_cnt;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_data = 8'h00;
    int          k;

    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous-read memory: data appears the cycle after the strobe.
    always @(posedge CLK) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    always @(posedge CLK) begin
        #1;
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cyc % 3 == 0);
            default: tx_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: labels the state seen after edge N as cycle N+1.
    always @(negedge CLK) begin
        if (!RST) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!tx_valid || tx_data != stall_data) begin
                    errors++;
                    $display("FAIL stall_hold: got valid %0b data %0h expected valid 1 data %0h",
                             tx_valid, tx_data, stall_data);
                end
            end
            if (mem_rd_en) begin
                if (rd_addr_q.size() == 0) rd_first_cyc = cyc + 1;
                rd_addr_q.push_back(mem_addr);
            end
            if (tx_valid && first_valid < 0) first_valid = cyc + 1;
            if (cpu_hold) hold_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc + 1; end
            checks++;
            if (cpu_hold !== busy) begin
                errors++;
                $display("FAIL cpu_hold_eq_busy: got %0b expected %0b", cpu_hold, busy);
            end
            if (tx_valid && tx_ready) begin
                byte_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_byte: got %0h expected no byte", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got %0h expected %0h", tx_data, e);
                    end
                end
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    task automatic push_bytes(input logic [15:0] w);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic wait_done(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if (done) begin seen = 1'b1; break; end
        end
        chk("done_within_bound", seen, 1);
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] len, input int mode, input bit restart);
        rdy_mode = mode;
        rd_addr_q.delete();
        rd_first_cyc = -1; first_valid = -1; done_cnt = 0; done_cyc = -1;
        byte_cnt = 0; hold_cnt = 0;
        @(posedge CLK); #1;
        start_addr = a; length = len; start = 1'b1;
        @(posedge CLK); #1;
        k = cyc;
        start = 1'b0;
        if (restart) begin
            repeat (2) @(posedge CLK);
            #1 start = 1'b1; start_addr = 16'h0010; length = 16'd1;
            @(posedge CLK); #1 start = 1'b0;
        end
        wait_done(400);
        repeat (3) @(negedge CLK);
        chk("all_bytes_sent", exp_q.size(), 0);
        chk("done_once", done_cnt, 1);
        chk("read_count", rd_addr_q.size(), len);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[0] = 16'h4041; mem[1] = 16'h1234;
        mem[16'hFFFF] = 16'hAAAA;
        mem[16'h0010] = 16'hFFFF; mem[16'h0011] = 16'h0002;
        mem[16'h0020] = 16'hBEEF; mem[16'h0021] = 16'hCAFE;

        #3;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_tx_data", tx_data, 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;

        // Basic two-word dump, sink always ready.
        push_bytes(16'h4041); push_bytes(16'h1234);
`ifdef DUMP_CHECKSUM_EN
        push_bytes(16'h5275);
`endif
        run(16'h0000, 16'd2, 0, 1'b0);
        chk("t1_first_rd_addr", rd_addr_q[0], 16'h0000);
        chk("t1_first_rd_cycle", rd_first_cyc, k + 1);
        chk("t1_first_valid_cycle", first_valid, k + 3);
`ifdef DUMP_CHECKSUM_EN
        chk("t1_hold_cycles", hold_cnt, 10);
`else
        chk("t1_hold_cycles", hold_cnt, 8);
`endif

        // Same data, sink ready one cycle in three.
        push_bytes(16'h4041); push_bytes(16'h1234);
`ifdef DUMP_CHECKSUM_EN
        push_bytes(16'h5275);
`endif
        run(16'h0000, 16'd2, 1, 1'b0);
        chk("t2_byte_count", byte_cnt, 4 + ((exp_q.size() == 0) ? 0 : 0)
`ifdef DUMP_CHECKSUM_EN
            + 2
`endif
            );

        // Address wrap from the top of memory.
        mem[0] = 16'h5555;
        push_bytes(16'hAAAA); push_bytes(16'h5555);
`ifdef DUMP_CHECKSUM_EN
        push_bytes(16'hFFFF);
`endif
        run(16'hFFFF, 16'd2, 0, 1'b0);
        chk("t3_rd_addr0", rd_addr_q[0], 16'hFFFF);
        chk("t3_rd_addr1_wrapped", rd_addr_q[1], 16'h0000);

        // Zero-length dump.
`ifdef DUMP_CHECKSUM_EN
        push_bytes(16'h0000);
`endif
        run(16'h0005, 16'd0, 0, 1'b0);
`ifdef DUMP_CHECKSUM_EN
        chk("t4_byte_count", byte_cnt, 2);
        chk("t4_hold_cycles", hold_cnt, 2);
`else
        chk("t4_byte_count", byte_cnt, 0);
        chk("t4_done_cycle", done_cyc, k + 2);
        chk("t4_hold_cycles", hold_cnt, 1);
`endif

        // Checksum carry case; plain data bytes in the default build.
        push_bytes(16'hFFFF); push_bytes(16'h0002);
`ifdef DUMP_CHECKSUM_EN
        push_bytes(16'h0001);
`endif
        run(16'h0010, 16'd2, 1, 1'b0);

        // Reset while a byte is stalled in SEND_HI.
        rdy_mode = 2;
        @(posedge CLK); #1;
        start_addr = 16'h0020; length = 16'd2; start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge CLK);
                if (tx_valid) begin seen = 1'b1; break; end
            end
            chk("t6_reached_send_hi", seen, 1);
        end
        #1 RST = 1'b0;
        #1;
        chk("t6_rst_tx_valid", tx_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_cpu_hold", cpu_hold, 0);
        chk("t6_rst_tx_data", tx_data, 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        chk("t6_idle_after_release", busy, 0);
        push_bytes(16'hBEEF); push_bytes(16'hCAFE);
`ifdef DUMP_CHECKSUM_EN
        push_bytes(16'h89ED);
`endif
        run(16'h0020, 16'd2, 0, 1'b1);
        chk("t6_rd_addr0", rd_addr_q[0], 16'h0020);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
